// File: rtl/simon_control_pkg.sv
// Shared definitions for the Simon game controller and its datapath.
// Holds the FSM state encoding and the mode LED patterns shown for each
// state, so the controller, datapath and top level all agree on them.
package simon_control_pkg;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] LED_INPUT    = 3'b001;
  localparam logic [2:0] LED_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_REPEAT   = 3'b100;
  localparam logic [2:0] LED_DONE     = 3'b111;

  // Mode LED pattern for a given state.
  function automatic logic [2:0] state_leds(input state_e st);
    case (st)
      ST_INPUT:    state_leds = LED_INPUT;
      ST_PLAYBACK: state_leds = LED_PLAYBACK;
      ST_REPEAT:   state_leds = LED_REPEAT;
      default:     state_leds = LED_DONE;
    endcase
  endfunction

endpackage

// File: rtl/simon_control_if.sv
// Control/status bundle between the Simon controller and its datapath.
//   Status (datapath -> controller): pattern_valid, index_lt_count,
//     pattern_eq_mem.
//   Control (controller -> datapath): count_cnt, count_clr, index_cnt,
//     index_clr, disp_mem, w_en, load_level, mode_leds[2:0].
// master = controller side, slave = datapath side.
interface simon_control_if;

  logic       pattern_valid;
  logic       index_lt_count;
  logic       pattern_eq_mem;

  logic       count_cnt;
  logic       count_clr;
  logic       index_cnt;
  logic       index_clr;
  logic       disp_mem;
  logic       w_en;
  logic       load_level;
  logic [2:0] mode_leds;

  modport master (
    input  pattern_valid, index_lt_count, pattern_eq_mem,
    output count_cnt, count_clr, index_cnt, index_clr,
           disp_mem, w_en, load_level, mode_leds
  );

  modport slave (
    output pattern_valid, index_lt_count, pattern_eq_mem,
    input  count_cnt, count_clr, index_cnt, index_clr,
           disp_mem, w_en, load_level, mode_leds
  );

endinterface

// File: rtl/simon_control.sv
// Simon game controller FSM: INPUT -> PLAYBACK -> REPEAT -> (INPUT | DONE).
// Strobes are combinational from the current state, rst and the status
// inputs, so the datapath acts on them in the same cycle.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset; returns the FSM to INPUT and
//          forces the clear/load strobes while held
//   bus  - simon_control_if.master carrying status in and strobes out
module simon_control
  import simon_control_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  simon_control_if.master   bus
);

  state_e state_q, state_d;

  logic count_cnt, count_clr, index_cnt, index_clr;
  logic disp_mem, w_en, load_level;

  // State register (power-up state is left undefined until the first reset)
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INPUT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    count_cnt  = 1'b0;
    count_clr  = 1'b0;
    index_cnt  = 1'b0;
    index_clr  = 1'b0;
    disp_mem   = 1'b0;
    w_en       = 1'b0;
    load_level = 1'b0;

    case (state_q)
      ST_INPUT: begin
        if (bus.pattern_valid) begin
          w_en      = 1'b1;
          index_clr = 1'b1;
          state_d   = ST_PLAYBACK;
        end
      end
      ST_PLAYBACK: begin
        disp_mem = 1'b1;
        if (bus.index_lt_count) begin
          index_cnt = 1'b1;
        end else begin
          index_clr = 1'b1;
          state_d   = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        if (!bus.pattern_eq_mem) begin
          // A wrong entry ends the game; restart the index for the replay.
          index_clr = 1'b1;
          state_d   = ST_DONE;
        end else if (bus.index_lt_count) begin
          index_cnt = 1'b1;
        end else begin
          // Whole sequence matched: grow the level and take a new entry.
          count_cnt = 1'b1;
          state_d   = ST_INPUT;
        end
      end
      ST_DONE: begin
        // Replay the stored sequence endlessly until reset.
        disp_mem = 1'b1;
        if (bus.index_lt_count) index_cnt = 1'b1;
        else                    index_clr = 1'b1;
      end
      default: state_d = ST_INPUT;
    endcase

    // Reset overrides every strobe regardless of state or inputs.
    if (rst) begin
      count_cnt  = 1'b0;
      count_clr  = 1'b1;
      index_cnt  = 1'b0;
      index_clr  = 1'b1;
      disp_mem   = 1'b0;
      w_en       = 1'b0;
      load_level = 1'b1;
    end
  end

  assign bus.count_cnt  = count_cnt;
  assign bus.count_clr  = count_clr;
  assign bus.index_cnt  = index_cnt;
  assign bus.index_clr  = index_clr;
  assign bus.disp_mem   = disp_mem;
  assign bus.w_en       = w_en;
  assign bus.load_level = load_level;
  assign bus.mode_leds  = state_leds(state_q);

endmodule

// File: tb/tb_simon_control.sv
// Directed testbench for simon_control.
module tb_simon_control;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  simon_control_if bus ();

  simon_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic pv, input logic ilc, input logic peq);
    bus.pattern_valid  = pv;
    bus.index_lt_count = ilc;
    bus.pattern_eq_mem = peq;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0);
    checks++; if (bus.count_clr !== 1'b1) begin errors++; $display("FAIL rst_count_clr got %b want 1", bus.count_clr); end
    checks++; if (bus.load_level !== 1'b1) begin errors++; $display("FAIL rst_load_level got %b want 1", bus.load_level); end
    checks++; if (bus.index_clr !== 1'b1) begin errors++; $display("FAIL rst_index_clr got %b want 1", bus.index_clr); end
    checks++; if ({bus.index_cnt, bus.count_cnt, bus.w_en, bus.disp_mem} !== 4'b0000) begin errors++; $display("FAIL rst_others got %b want 0000", {bus.index_cnt, bus.count_cnt, bus.w_en, bus.disp_mem}); end
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    checks++; if (bus.count_clr !== 1'b0) begin errors++; $display("FAIL post_rst_count_clr got %b want 0", bus.count_clr); end
    checks++; if (bus.load_level !== 1'b0) begin errors++; $display("FAIL post_rst_load_level got %b want 0", bus.load_level); end
    checks++; if (bus.mode_leds !== 3'b001) begin errors++; $display("FAIL post_rst_mode got %b want 001", bus.mode_leds); end
  endtask

  task automatic test_input_idle();
    set_in(1'b0, 1'b1, 1'b1);
    checks++; if (bus.w_en !== 1'b0 || bus.index_clr !== 1'b0 || bus.disp_mem !== 1'b0) begin errors++; $display("FAIL idle_strobes got w_en=%b index_clr=%b disp_mem=%b want 0 0 0", bus.w_en, bus.index_clr, bus.disp_mem); end
    tick();
    checks++; if (bus.mode_leds !== 3'b001) begin errors++; $display("FAIL idle_stay got %b want 001", bus.mode_leds); end
  endtask

  task automatic test_input_to_playback();
    set_in(1'b1, 1'b0, 1'b0);
    checks++; if (bus.w_en !== 1'b1 || bus.index_clr !== 1'b1 || bus.disp_mem !== 1'b0 || bus.index_cnt !== 1'b0) begin errors++; $display("FAIL input_accept got w_en=%b index_clr=%b disp_mem=%b index_cnt=%b want 1 1 0 0", bus.w_en, bus.index_clr, bus.disp_mem, bus.index_cnt); end
    tick();
    set_in(1'b0, 1'b1, 1'b0);
    checks++; if (bus.mode_leds !== 3'b010 || bus.disp_mem !== 1'b1) begin errors++; $display("FAIL enter_playback got mode=%b disp_mem=%b want 010 1", bus.mode_leds, bus.disp_mem); end
  endtask

  task automatic test_playback();
    set_in(1'b0, 1'b1, 1'b0);
    checks++; if (bus.index_cnt !== 1'b1 || bus.index_clr !== 1'b0) begin errors++; $display("FAIL playback_step got index_cnt=%b index_clr=%b want 1 0", bus.index_cnt, bus.index_clr); end
    tick();
    checks++; if (bus.mode_leds !== 3'b010) begin errors++; $display("FAIL playback_stay got %b want 010", bus.mode_leds); end
    set_in(1'b0, 1'b0, 1'b0);
    checks++; if (bus.index_clr !== 1'b1 || bus.index_cnt !== 1'b0) begin errors++; $display("FAIL playback_end got index_clr=%b index_cnt=%b want 1 0", bus.index_clr, bus.index_cnt); end
    tick();
    checks++; if (bus.mode_leds !== 3'b100 || bus.disp_mem !== 1'b0) begin errors++; $display("FAIL enter_repeat got mode=%b disp_mem=%b want 100 0", bus.mode_leds, bus.disp_mem); end
  endtask

  task automatic test_repeat_success();
    set_in(1'b0, 1'b1, 1'b1);
    checks++; if (bus.index_cnt !== 1'b1 || bus.count_cnt !== 1'b0 || bus.index_clr !== 1'b0) begin errors++; $display("FAIL repeat_step got index_cnt=%b count_cnt=%b index_clr=%b want 1 0 0", bus.index_cnt, bus.count_cnt, bus.index_clr); end
    tick();
    checks++; if (bus.mode_leds !== 3'b100) begin errors++; $display("FAIL repeat_stay got %b want 100", bus.mode_leds); end
    set_in(1'b0, 1'b0, 1'b1);
    checks++; if (bus.count_cnt !== 1'b1 || bus.index_clr !== 1'b0 || bus.disp_mem !== 1'b0 || bus.index_cnt !== 1'b0 || bus.count_clr !== 1'b0) begin errors++; $display("FAIL repeat_win got count_cnt=%b index_clr=%b disp_mem=%b index_cnt=%b count_clr=%b want 1 0 0 0 0", bus.count_cnt, bus.index_clr, bus.disp_mem, bus.index_cnt, bus.count_clr); end
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    checks++; if (bus.mode_leds !== 3'b001 || bus.w_en !== 1'b0) begin errors++; $display("FAIL back_to_input got mode=%b w_en=%b want 001 0", bus.mode_leds, bus.w_en); end
    tick();
    checks++; if (bus.mode_leds !== 3'b001) begin errors++; $display("FAIL input_hold got %b want 001", bus.mode_leds); end
  endtask

  task automatic test_done();
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.mode_leds !== 3'b100) begin errors++; $display("FAIL reenter_repeat got %b want 100", bus.mode_leds); end
    set_in(1'b0, 1'b1, 1'b0);
    checks++; if (bus.index_clr !== 1'b1 || bus.index_cnt !== 1'b0 || bus.count_cnt !== 1'b0) begin errors++; $display("FAIL repeat_miss got index_clr=%b index_cnt=%b count_cnt=%b want 1 0 0", bus.index_clr, bus.index_cnt, bus.count_cnt); end
    tick();
    checks++; if (bus.mode_leds !== 3'b111 || bus.disp_mem !== 1'b1) begin errors++; $display("FAIL enter_done got mode=%b disp_mem=%b want 111 1", bus.mode_leds, bus.disp_mem); end
    checks++; if (bus.index_cnt !== 1'b1 || bus.index_clr !== 1'b0) begin errors++; $display("FAIL done_step got index_cnt=%b index_clr=%b want 1 0", bus.index_cnt, bus.index_clr); end
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    checks++; if (bus.index_clr !== 1'b1 || bus.index_cnt !== 1'b0) begin errors++; $display("FAIL done_wrap got index_clr=%b index_cnt=%b want 1 0", bus.index_clr, bus.index_cnt); end
    tick();
    set_in(1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (bus.mode_leds !== 3'b111 || bus.w_en !== 1'b0 || bus.count_cnt !== 1'b0) begin errors++; $display("FAIL done_hold got mode=%b w_en=%b count_cnt=%b want 111 0 0", bus.mode_leds, bus.w_en, bus.count_cnt); end
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b1);
    checks++; if (bus.count_clr !== 1'b1 || bus.disp_mem !== 1'b0 || bus.index_cnt !== 1'b0) begin errors++; $display("FAIL done_rst_strobes got count_clr=%b disp_mem=%b index_cnt=%b want 1 0 0", bus.count_clr, bus.disp_mem, bus.index_cnt); end
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    checks++; if (bus.mode_leds !== 3'b001) begin errors++; $display("FAIL done_rst_mode got %b want 001", bus.mode_leds); end
  endtask

  task automatic test_reset_mid_playback();
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0);
    checks++; if (bus.mode_leds !== 3'b010) begin errors++; $display("FAIL mid_pb_mode got %b want 010", bus.mode_leds); end
    rst = 1'b1;
    #1;
    checks++; if (bus.count_clr !== 1'b1 || bus.load_level !== 1'b1 || bus.index_cnt !== 1'b0 || bus.index_clr !== 1'b1 || bus.disp_mem !== 1'b0) begin errors++; $display("FAIL mid_pb_rst got count_clr=%b load_level=%b index_cnt=%b index_clr=%b disp_mem=%b want 1 1 0 1 0", bus.count_clr, bus.load_level, bus.index_cnt, bus.index_clr, bus.disp_mem); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.mode_leds !== 3'b001) begin errors++; $display("FAIL mid_pb_after got %b want 001", bus.mode_leds); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pattern_valid  = 1'b0;
    bus.index_lt_count = 1'b0;
    bus.pattern_eq_mem = 1'b0;
    test_reset();
    test_input_idle();
    test_input_to_playback();
    test_playback();
    test_repeat_success();
    test_done();
    test_reset_mid_playback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
